// File: rtl/obi_rr_mux.sv
// N-master to 1-slave OBI request/response multiplexer: round-robin arbitration
// with address-phase locking, and an in-order ID FIFO that routes responses back.
module obi_rr_mux #(
  parameter int NR_MASTERS      = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  localparam int BW = DATA_WIDTH / 8,
  localparam int IW = $clog2(NR_MASTERS),
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NR_MASTERS-1:0]           m_req_i,
  input  logic [NR_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NR_MASTERS-1:0]           m_we_i,
  input  logic [NR_MASTERS*BW-1:0]        m_be_i,
  input  logic [NR_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [NR_MASTERS-1:0]           m_gnt_o,
  output logic [NR_MASTERS-1:0]           m_rvalid_o,
  output logic [DATA_WIDTH-1:0]           m_rdata_o,
  output logic                            s_req_o,
  output logic [ADDR_WIDTH-1:0]           s_addr_o,
  output logic                            s_we_o,
  output logic [BW-1:0]                   s_be_o,
  output logic [DATA_WIDTH-1:0]           s_wdata_o,
  input  logic                            s_gnt_i,
  input  logic                            s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]           s_rdata_i,
  output logic [CW-1:0]                   outstanding_o,
  output logic                            err_o
);

  // Handshake rule: a request transfers on the cycle where s_req_o && s_gnt_i;
  // a response transfers on any cycle with s_rvalid_i (no backpressure).

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NR_MASTERS - 1);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t     r_state;
  logic [IW-1:0]   r_locked_idx;
  logic [IW-1:0]   r_rr_ptr;
  logic            r_err;

  logic [IW-1:0]   r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [IW-1:0]   w_rr_sel;
  logic            w_rr_hit;
  logic [IW-1:0]   w_sel;
  logic            w_full;
  logic            w_empty;
  logic            w_sreq;
  logic            w_push;
  logic            w_pop;
  logic [IW-1:0]   w_head;
  logic [NR_MASTERS-1:0] w_gnt;
  logic [NR_MASTERS-1:0] w_rvalid;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NR_MASTERS) s = s - NR_MASTERS;
    return IW'(s);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search starting at r_rr_ptr; falls back to r_rr_ptr when idle.
  always_comb begin
    w_rr_sel = r_rr_ptr;
    w_rr_hit = 1'b0;
    for (int i = 0; i < NR_MASTERS; i++) begin
      if (!w_rr_hit && m_req_i[rr_idx(r_rr_ptr, i)]) begin
        w_rr_sel = rr_idx(r_rr_ptr, i);
        w_rr_hit = 1'b1;
      end
    end
  end

  assign w_sel   = (r_state == ST_LOCKED) ? r_locked_idx : w_rr_sel;
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Full is judged on the registered count, so a same-cycle pop never unblocks.
  assign w_sreq  = m_req_i[w_sel] && !w_full;
  assign w_push  = w_sreq && s_gnt_i;
  assign w_pop   = s_rvalid_i && !w_empty;
  assign w_head  = r_fifo[r_rd_ptr];

  always_comb begin
    w_gnt = '0;
    if (w_push) w_gnt[w_sel] = 1'b1;
  end

  always_comb begin
    w_rvalid = '0;
    if (w_pop) w_rvalid[w_head] = 1'b1;
  end

  assign s_req_o   = w_sreq;
  assign s_addr_o  = w_sreq ? m_addr_i[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign s_we_o    = w_sreq ? m_we_i[w_sel] : 1'b0;
  assign s_be_o    = w_sreq ? m_be_i[int'(w_sel)*BW +: BW] : '0;
  assign s_wdata_o = w_sreq ? m_wdata_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign m_gnt_o       = w_gnt;
  assign m_rvalid_o    = w_rvalid;
  assign m_rdata_o     = s_rdata_i;
  assign outstanding_o = r_count;
  assign err_o         = r_err;

  // Address-phase lock: once offered, the slave keeps seeing the same master.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_OPEN;
      r_locked_idx <= '0;
    end else begin
      case (r_state)
        ST_OPEN: begin
          if (w_sreq && !s_gnt_i) begin
            r_state      <= ST_LOCKED;
            r_locked_idx <= w_sel;
          end
        end
        ST_LOCKED: begin
          if (!m_req_i[r_locked_idx] || w_push) r_state <= ST_OPEN;
        end
        default: r_state <= ST_OPEN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= (w_sel == LAST_IDX) ? '0 : w_sel + 1'b1;
    end
  end

  // Sticky: a locked master abandoning its request, or a response with no owner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_LOCKED && !m_req_i[r_locked_idx]) ||
                 (s_rvalid_i && w_empty)) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_sel;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(m_gnt_o));
  a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(m_rvalid_o));
  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i) r_count <= FULL_CNT);
`endif

endmodule

// File: doc/obi_rr_mux.md
Name: obi_rr_mux

Overview:
- Parametrised N-master to 1-slave OBI-style request/response multiplexer for the verilator testbench.
- Replaces the fixed-wiring "grant same cycle, rvalid next cycle" glue between core data port, debug-module system-bus master and memory, so any number of masters can share one slave.
- Arbitration is round-robin with address-phase locking.
- An in-order ID FIFO routes each response back to the master that issued the request.

Parameters:
- NR_MASTERS, 3, number of master ports (≥2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width, multiple of 8; BE width = DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, depth of the response-ID FIFO (≥1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m_req_i  in  NR_MASTERS  per-master request
- m_addr_i  in  NR_MASTERS*ADDR_WIDTH  packed addresses, master k at slice k
- m_we_i  in  NR_MASTERS  write enable
- m_be_i  in  NR_MASTERS*DATA_WIDTH/8  byte enables
- m_wdata_i  in  NR_MASTERS*DATA_WIDTH  write data
- m_gnt_o  out  NR_MASTERS  grant, one-hot or zero
- m_rvalid_o  out  NR_MASTERS  response valid, one-hot or zero
- m_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters
- s_req_o  out  1  slave request
- s_addr_o  out  ADDR_WIDTH  slave address
- s_we_o  out  1  slave write enable
- s_be_o  out  DATA_WIDTH/8  slave byte enables
- s_wdata_o  out  DATA_WIDTH  slave write data
- s_gnt_i  in  1  slave grant
- s_rvalid_i  in  1  slave response valid
- s_rdata_i  in  DATA_WIDTH  slave read data
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy
- err_o  out  1  sticky protocol-error flag

Behaviour:
- One clock, clk_i; reset is synchronous and active-high (rst_i). All state updates on posedge clk_i.
- Reset values: rr_ptr=0, lock=0, FIFO empty, err_o=0. Hence at reset outstanding_o=0, m_rvalid_o=0, and s_req_o=0 unless a master is requesting.

Arbitration (combinational):
- With lock=0, sel = first k with m_req_i[k]=1, searching k=rr_ptr, rr_ptr+1, … mod NR_MASTERS.
- With lock=1, sel = locked_idx.
- s_req_o = m_req_i[sel] && !full. s_addr/we/be/wdata are the fields of master sel.
- When s_req_o=0: addr, be and wdata outputs are 0; we is 0.
- m_gnt_o[sel] = s_req_o && s_gnt_i. All other grant bits are 0.

Address-phase lock:
- If s_req_o=1 and s_gnt_i=0: lock<=1, locked_idx<=sel.
- Cleared on the handshake cycle (s_req_o && s_gnt_i).
- A locked master dropping m_req_i before its grant: err_o<=1 and lock<=0.

Handshake:
- On s_req_o && s_gnt_i: push sel into the ID FIFO and set rr_ptr <= (sel+1) mod NR_MASTERS.
- Wrap: sel=NR_MASTERS-1 gives rr_ptr=0.

Response:
- On s_rvalid_i with FIFO non-empty: pop head h; m_rvalid_o[h]=1 in the same cycle; m_rdata_o = s_rdata_i.
- m_rdata_o always equals s_rdata_i (pass-through).
- Slave latency is ≥1 cycle: an rvalid only retires requests granted in earlier cycles.

Boundary conditions:
- Full (count==MAX_OUTSTANDING): s_req_o=0, no grant, lock unchanged. A simultaneous pop does NOT unblock the request in that cycle, so full blocks for one cycle after a pop.
- Simultaneous push and pop: count is unchanged; pointers advance; FIFO wraps modulo MAX_OUTSTANDING.
- s_rvalid_i with FIFO empty: no m_rvalid_o; err_o<=1.
- err_o holds until reset.
- Reset mid-transaction: FIFO, lock and rr_ptr cleared. The slave shares rst_i, so in-flight responses are discarded by both sides.

Test Plan:
- Single master: m_req_i=3'b010, addr 0x1C00_0000, s_gnt_i=1 → m_gnt_o=3'b010 the same cycle. Next cycle s_rvalid_i=1, s_rdata_i=0xDEAD_BEEF → m_rvalid_o=3'b010, m_rdata_o=0xDEAD_BEEF, outstanding 1→0.
- Round robin: all three requesting, s_gnt_i=1 continuously → grants 001, 010, 100, 001 on consecutive cycles. Later responses route in the same order.
- Lock: s_gnt_i=0 for 3 cycles with master 1 selected, then master 0 also requests → s_addr_o stays master 1's address. Master 1 is granted when s_gnt_i=1; master 0 follows.
- Full: MAX_OUTSTANDING=2, two grants with no rvalid → s_req_o=0 and outstanding_o=2. rvalid → outstanding_o=1 and s_req_o=1 the following cycle.
- Push+pop same cycle: grant to master 2 while rvalid retires master 0 → m_rvalid_o=3'b001 and outstanding_o unchanged.
- Errors: s_rvalid_i with empty FIFO → err_o=1 next cycle and stays 1. rst_i=1 for 1 cycle → err_o=0, outstanding_o=0, next grant starts from master 0.
